// File: rtl/regs16_pkg.sv
// Shared types and sizes for the 16x32 register file and its writeback path.
package regs16_pkg;

  localparam int RF_AW    = 4;
  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 16;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  typedef struct packed {
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on conflict the side that did not win last time
// is granted. Grant is one-hot (or zero when nothing is requested).
module rr_arb2
  import regs16_pkg::*;
(
  input  logic [1:0] valid,
  input  grant_e     last_grant,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: default first so every path assigns grant and no latch is inferred.
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == GRANT_B) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/regs16_wb_arbiter.sv
// Shares the regs16 write port between ALU (A) and load (B) writeback, round-robin.
// Optional same-cycle read forwarding when REGS16_WB_BYPASS_EN is defined.
module regs16_wb_arbiter
  import regs16_pkg::*;
#(
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW-1:0]   a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [AW-1:0]   b_addr,
  input  logic [DW-1:0]   b_data,
  output logic            rf_wen,
  output logic [AW-1:0]   rf_waddr,
  output logic [DW-1:0]   rf_wdata,
  output logic            last_grant,
  output logic [CNTW-1:0] stall_cnt
`ifdef REGS16_WB_BYPASS_EN
  ,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  input  logic [DW-1:0]   rf_rdata1,
  input  logic [DW-1:0]   rf_rdata2,
  output logic [DW-1:0]   fwd_data1,
  output logic [DW-1:0]   fwd_data2
`endif
);

  grant_e     last_q;
  logic [1:0] grant;
  logic       a_xfer;
  logic       b_xfer;
  logic       stall;

  rr_arb2 u_arb (
    .valid      ({b_valid, a_valid}),
    .last_grant (last_q),
    .grant      (grant)
  );

  // Nothing is accepted while in reset, so an in-flight request simply retries.
  assign a_ready    = grant[0] & ~rst;
  assign b_ready    = grant[1] & ~rst;
  assign a_xfer     = a_valid & a_ready;
  assign b_xfer     = b_valid & b_ready;
  assign stall      = (a_valid & ~a_ready) | (b_valid & ~b_ready);
  assign last_grant = last_q;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers sample pre-edge values.
    if (rst) begin
      rf_wen    <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      last_q    <= GRANT_B;
      stall_cnt <= '0;
    end else begin
      rf_wen <= a_xfer | b_xfer;
      if (a_xfer) begin
        rf_waddr <= a_addr;
        rf_wdata <= a_data;
        last_q   <= GRANT_A;
      end else if (b_xfer) begin
        rf_waddr <= b_addr;
        rf_wdata <= b_data;
        last_q   <= GRANT_B;
      end
      if (stall && (stall_cnt != {CNTW{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

`ifdef REGS16_WB_BYPASS_EN
  // The committed write lands in regs16 one edge later; forward it meanwhile.
  assign fwd_data1 = (rf_wen && (rf_waddr == raddr1)) ? rf_wdata : rf_rdata1;
  assign fwd_data2 = (rf_wen && (rf_waddr == raddr2)) ? rf_wdata : rf_rdata2;
`endif

endmodule

// File: tb/tb_regs16_wb_arbiter.sv
// Scoreboard bench for regs16_wb_arbiter: a spec-level model predicts grants,
// counters and commits; a monitor pops expected commits whenever rf_wen is seen.
module tb_regs16_wb_arbiter;
  import regs16_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [3:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;

  logic        a_ready, b_ready, rf_wen, last_grant;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] stall_cnt;

  logic        a_ready4, b_ready4, rf_wen4, last_grant4;
  logic [3:0]  rf_waddr4;
  logic [31:0] rf_wdata4;
  logic [3:0]  stall_cnt4;

  logic [31:0] rf_mem [RF_DEPTH];

`ifdef REGS16_WB_BYPASS_EN
  logic [3:0]  raddr1, raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [31:0] fwd_data1, fwd_data2, fwd4_data1, fwd4_data2;
  assign rf_rdata1 = rf_mem[raddr1];
  assign rf_rdata2 = rf_mem[raddr2];
`endif

  regs16_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .last_grant(last_grant), .stall_cnt(stall_cnt)
`ifdef REGS16_WB_BYPASS_EN
    , .raddr1(raddr1), .raddr2(raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
  );

  regs16_wb_arbiter #(.CNTW(4)) dut_sat (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready4), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready4), .b_addr(b_addr), .b_data(b_data),
    .rf_wen(rf_wen4), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4),
    .last_grant(last_grant4), .stall_cnt(stall_cnt4)
`ifdef REGS16_WB_BYPASS_EN
    , .raddr1(raddr1), .raddr2(raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_data1(fwd4_data1), .fwd_data2(fwd4_data2)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in for regs16: writes on the edge after rf_wen is presented.
  always @(posedge clk) if (rf_wen) rf_mem[rf_waddr] <= rf_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  wb_req_t     q[$];
  logic [31:0] model_rf [RF_DEPTH];
  int          m_cnt;
  grant_e      m_last;
  logic        m_wen;
  logic [3:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        a_acc, b_acc;
  logic        ea, eb;

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  initial begin
    m_cnt = 0; m_last = GRANT_B; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
    a_acc = 1'b0; b_acc = 1'b0;
    for (int i = 0; i < RF_DEPTH; i++) model_rf[i] = '0;
    forever begin
      @(negedge clk);
      check("rf_wen", rf_wen, m_wen);
      check("rf_wen_sat", rf_wen4, m_wen);
      check("rf_waddr", rf_waddr, m_waddr);
      check("rf_wdata", rf_wdata, m_wdata);
      check("last_grant", last_grant, m_last);
      check("last_grant_sat", last_grant4, m_last);
      check("stall_cnt", stall_cnt, sat(m_cnt, 65535));
      check("stall_cnt_sat", stall_cnt4, sat(m_cnt, 15));
`ifdef REGS16_WB_BYPASS_EN
      check("fwd_data1", fwd_data1, (m_wen && m_waddr == raddr1) ? m_wdata : rf_mem[raddr1]);
      check("fwd_data2", fwd_data2, (m_wen && m_waddr == raddr2) ? m_wdata : rf_mem[raddr2]);
      check("fwd_data1_sat", fwd4_data1, (m_wen && m_waddr == raddr1) ? m_wdata : rf_mem[raddr1]);
`endif
      if (rst) begin
        ea = 1'b0; eb = 1'b0;
      end else if (a_valid && b_valid) begin
        ea = (m_last == GRANT_B); eb = ~ea;
      end else begin
        ea = a_valid; eb = b_valid;
      end
      check("a_ready", a_ready, ea);
      check("b_ready", b_ready, eb);
      check("a_ready_sat", a_ready4, ea);
      check("b_ready_sat", b_ready4, eb);
      a_acc = a_valid && ea;
      b_acc = b_valid && eb;
      if (rst) begin
        m_cnt = 0; m_last = GRANT_B; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
      end else begin
        m_wen = a_acc || b_acc;
        if (a_acc) begin
          q.push_back(wb_req_t'{a_addr, a_data});
          model_rf[a_addr] = a_data; m_waddr = a_addr; m_wdata = a_data; m_last = GRANT_A;
        end
        if (b_acc) begin
          q.push_back(wb_req_t'{b_addr, b_data});
          model_rf[b_addr] = b_data; m_waddr = b_addr; m_wdata = b_data; m_last = GRANT_B;
        end
        if ((a_valid && !ea) || (b_valid && !eb)) m_cnt++;
      end
    end
  end

  // Monitor: every presented write must match the oldest accepted request.
  initial begin
    wb_req_t exp;
    forever begin
      @(negedge clk);
      if (rf_wen) begin
        if (q.size() == 0) begin
          check("commit_unexpected", 1'b1, 1'b0);
        end else begin
          exp = q.pop_front();
          check("commit_addr", rf_waddr, exp.addr);
          check("commit_data", rf_wdata, exp.data);
          check("commit_addr_sat", rf_waddr4, exp.addr);
          check("commit_data_sat", rf_wdata4, exp.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [3:0] ad, input logic [31:0] d);
    a_valid = v; a_addr = ad; a_data = d;
  endtask

  task automatic set_b(input logic v, input logic [3:0] ad, input logic [31:0] d);
    b_valid = v; b_addr = ad; b_data = d;
  endtask

  // Drop each valid once accepted; a request still pending after the bound is a failure.
  task automatic drain(input int bound);
    int n = 0;
    while ((a_valid || b_valid) && n < bound) begin
      step();
      if (a_acc) a_valid = 1'b0;
      if (b_acc) b_valid = 1'b0;
      n++;
    end
    check("drain_timeout", {a_valid, b_valid}, 2'b00);
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < RF_DEPTH; i++) rf_mem[i] = '0;
`ifdef REGS16_WB_BYPASS_EN
    raddr1 = 4'd0; raddr2 = 4'd0;
`endif
    rst = 1'b1;
    set_a(1'b1, 4'h9, 32'h1111);
    set_b(1'b1, 4'hA, 32'h2222);
    repeat (2) step();
    rst = 1'b0;
    set_a(1'b0, 4'h0, 32'h0);
    set_b(1'b0, 4'h0, 32'h0);
    step();

    // Single requester.
    set_a(1'b1, 4'd3, 32'h0000_0077);
    drain(4);
    repeat (2) step();

    // Conflict from the reset grant state.
    pulse_reset();
    set_a(1'b1, 4'd1, 32'h6D);
    set_b(1'b1, 4'd2, 32'h65);
    drain(6);
    repeat (2) step();

    // Same address: loser's data must end up in the register.
    pulse_reset();
    set_a(1'b1, 4'd5, 32'h20);
    set_b(1'b1, 4'd5, 32'h6F);
    drain(6);
    repeat (3) step();
    check("same_addr_final", rf_mem[5], 32'h6F);

    // Continuous conflict: grants alternate, narrow counter saturates.
    set_a(1'b1, 4'($urandom), $urandom);
    set_b(1'b1, 4'($urandom), $urandom);
    for (int i = 0; i < 40; i++) begin
      step();
      if (a_acc) set_a(1'b1, 4'($urandom), $urandom);
      if (b_acc) set_b(1'b1, 4'($urandom), $urandom);
    end
    check("sat_reached", stall_cnt4, 4'hF);
    drain(4);

    // Random traffic with occasional mid-operation resets.
    for (int i = 0; i < 600; i++) begin
      step();
      rst = ($urandom_range(0, 49) == 0);
      if (!a_valid || a_acc) set_a($urandom_range(0, 2) != 0, 4'($urandom), $urandom);
      if (!b_valid || b_acc) set_b($urandom_range(0, 2) != 0, 4'($urandom), $urandom);
`ifdef REGS16_WB_BYPASS_EN
      raddr1 = ($urandom_range(0, 1) == 1) ? rf_waddr : 4'($urandom);
      raddr2 = 4'($urandom);
`endif
    end
    rst = 1'b0;
    drain(10);
    repeat (3) step();
    check("queue_empty", q.size(), 0);
    for (int i = 0; i < RF_DEPTH; i++) check("rf_final", rf_mem[i], model_rf[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regs16_wb_arbiter.md
Name: regs16_wb_arbiter

Overview:
- Shares the single write port of the 16x32 register file (regs16) between two writeback requesters: A (ALU result) and B (load result).
- Requesters use a valid/ready handshake. Conflicts are resolved round-robin.
- The granted write is registered and presented to regs16 as a one-cycle wen pulse.
- The block sits between the execute/memory stages and regs16. It also keeps a saturating count of stall cycles for performance debug.

Parameters:
- AW, 4, register address width (16 registers).
- DW, 32, register data width.
- CNTW, 16, stall counter width.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A has a write pending.
- a_ready  out  1  A's write is accepted this cycle.
- a_addr  in  AW  A destination register.
- a_data  in  DW  A write data.
- b_valid  in  1  requester B has a write pending.
- b_ready  out  1  B's write is accepted this cycle.
- b_addr  in  AW  B destination register.
- b_data  in  DW  B write data.
- rf_wen  out  1  write enable to regs16.
- rf_waddr  out  AW  write address to regs16.
- rf_wdata  out  DW  write data to regs16.
- last_grant  out  1  0 = A granted most recently, 1 = B.
- stall_cnt  out  CNTW  saturating count of refused-request cycles.

Behaviour:
- Reset:
  - Synchronous, active-high on clk: at the first rising edge with rst=1, rf_wen=0, rf_waddr=0, rf_wdata=0, last_grant=1 (so A wins first), stall_cnt=0.
  - a_ready and b_ready are 0 while rst=1.
- Grant (combinational from current inputs and last_grant):
  - Only a_valid: a_ready=1.
  - Only b_valid: b_ready=1.
  - Both valid: grant the side NOT equal to last_grant; the other ready=0.
  - Neither valid: both ready=0.
  - At most one ready is high in any cycle.
- Handshake:
  - A transfer occurs on a cycle where valid&&ready.
  - A refused requester holds valid, addr and data stable until accepted; the block does not latch refused requests.
- Commit (latency 1):
  - On the edge after a transfer: rf_wen=1, rf_waddr/rf_wdata = the accepted addr/data, last_grant updated to the winner.
  - With no transfer: rf_wen=0; rf_waddr/rf_wdata hold their previous values; last_grant holds.
  - regs16 writes on the following edge, so a value is architecturally visible 2 edges after its handshake.
- Back-to-back: one write per cycle sustained; rf_wen may stay high on consecutive cycles.
- Same address, both valid: handled as a normal conflict. The loser commits one cycle later, so the final register value is the loser's data. Ordering between requesters is the pipeline's responsibility.
- stall_cnt:
  - Increments by 1 on each edge where a requester had valid=1 and ready=0; at most +1 per cycle.
  - Saturates at all-ones; no wrap.
- Reset mid-operation: a transfer accepted in the cycle rst is high is discarded (rf_wen=0 next cycle). A refused requester re-arbitrates after reset with A first.
- No state machine beyond the last_grant bit, the output register and the counter.

Optional Feature:
- Macro: REGS16_WB_BYPASS_EN.
- With the macro defined:
  - Added inputs: raddr1, raddr2 (AW), rf_rdata1, rf_rdata2 (DW, from regs16 data1/data2).
  - Added outputs: fwd_data1, fwd_data2 (DW).
  - fwd_dataN = rf_wdata when rf_wen && rf_waddr==raddrN, else rf_rdataN. This is combinational.
  - Readers therefore see the committed-but-not-yet-written value in the same cycle.
- Without the macro: these ports do not exist, and readers see regs16 data one cycle after rf_wen.

Decomposition:
- Shared package regs16_pkg holds:
  - localparams RF_AW=4, RF_DW=32, RF_DEPTH=16;
  - enum grant_e {GRANT_A=0, GRANT_B=1};
  - typedef wb_req_t {addr, data}.
- One sub-module, rr_arb2: 2-way round-robin arbiter (valids, last_grant in; one-hot grant out), reusable for a future memory-port arbiter.
- Counter and commit register stay in the top.

Test Plan:
- Reset: hold rst=1 for 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, rf_wen=0, stall_cnt=0, last_grant=1.
- Single requester: a_valid=1, a_addr=3, a_data=32'h0000_0077 for one cycle -> a_ready=1; next cycle rf_wen=1, rf_waddr=3, rf_wdata=32'h77; cycle after, rf_wen=0.
- Conflict: both valid continuously; A writes 1/32'h6D, B writes 2/32'h65 -> A accepted cycle 0, B cycle 1; rf_wen high 2 consecutive cycles with addrs 1 then 2; stall_cnt=1.
- Same address: A(5, 32'h20) and B(5, 32'h6F) both valid -> commit order A then B; a regs16 read of reg 5 afterwards returns 32'h6F.
- Saturation: CNTW=4, hold both valid for 40 cycles -> stall_cnt reaches 4'hF and stays; grants alternate A, B, A, B.
- Bypass (REGS16_WB_BYPASS_EN): B commits 8/32'h77, raddr1=8 in the rf_wen cycle -> fwd_data1=32'h77 while regs16 data1 still shows the old value; raddr1=7 -> fwd_data1=rf_rdata1.
